// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO: gray pointers cross through flop synchronisers.
// Each side keeps a registered level, almost flag and sticky error.
`timescale 1ns/10ps
module async_fifo_gray #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = (1 << ADDR_W) - 1,
  parameter int AE_THRESH   = 1
) (
  input  logic              wclk,
  input  logic              rclk,
  input  logic              nRst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  output logic              wr_almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              wr_overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_empty,
  output logic              rd_almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              rd_underflow
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE = AE_THRESH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0] wbin, wgray, wbin_nx, wgray_nx;
  logic [ADDR_W:0] rbin, rgray, rbin_nx, rgray_nx;
  logic [ADDR_W:0] rsync_bin, wsync_bin;
  logic [ADDR_W:0] wlevel_nx, rlevel_nx;
  logic [ADDR_W:0] rq [SYNC_STAGES];
  logic [ADDR_W:0] wq [SYNC_STAGES];
  logic [ADDR_W:0] rq_tail, wq_tail;
  logic            push, pop, full_nx, empty_nx;

  function automatic logic [ADDR_W:0] g2b(
    input logic [ADDR_W:0] g
  );
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign rq_tail = rq[SYNC_STAGES-1];
  assign wq_tail = wq[SYNC_STAGES-1];

  assign push      = wr_en & ~wr_full;
  assign wbin_nx   = wbin + {{ADDR_W{1'b0}}, push};
  assign wgray_nx  = wbin_nx ^ (wbin_nx >> 1);
  assign rsync_bin = g2b(rq_tail);
  assign wlevel_nx = wbin_nx - rsync_bin;
  // Full: writer is exactly one lap ahead of the synced reader.
  assign full_nx   = wgray_nx == {~rq_tail[ADDR_W -: 2],
                                  rq_tail[ADDR_W-2:0]};

  assign pop       = rd_en & ~rd_empty;
  assign rbin_nx   = rbin + {{ADDR_W{1'b0}}, pop};
  assign rgray_nx  = rbin_nx ^ (rbin_nx >> 1);
  assign wsync_bin = g2b(wq_tail);
  assign rlevel_nx = wsync_bin - rbin_nx;
  assign empty_nx  = rgray_nx == wq_tail;

  always_ff @(posedge wclk)
    if (push) mem[wbin[ADDR_W-1:0]] <= wr_data;

  always_ff @(posedge wclk or negedge nRst) begin
    if (!nRst) begin
      wbin           <= '0;
      wgray          <= '0;
      wr_full        <= 1'b0;
      wr_level       <= '0;
      wr_almost_full <= (AF_THRESH == 0);
      wr_overflow    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        rq[i] <= '0;
    end else begin
      wbin           <= wbin_nx;
      wgray          <= wgray_nx;
      wr_full        <= full_nx;
      wr_level       <= wlevel_nx;
      wr_almost_full <= wlevel_nx >= AF;
      if (wr_en & wr_full) wr_overflow <= 1'b1;
      rq[0] <= rgray;
      for (int i = 1; i < SYNC_STAGES; i++)
        rq[i] <= rq[i-1];
    end
  end

  always_ff @(posedge rclk or negedge nRst) begin
    if (!nRst) begin
      rbin            <= '0;
      rgray           <= '0;
      rd_empty        <= 1'b1;
      rd_level        <= '0;
      rd_almost_empty <= 1'b1;
      rd_underflow    <= 1'b0;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        wq[i] <= '0;
    end else begin
      rbin            <= rbin_nx;
      rgray           <= rgray_nx;
      rd_empty        <= empty_nx;
      rd_level        <= rlevel_nx;
      rd_almost_empty <= rlevel_nx <= AE;
      rd_valid        <= pop;
      if (pop) rd_data <= mem[rbin[ADDR_W-1:0]];
      if (rd_en & rd_empty) rd_underflow <= 1'b1;
      wq[0] <= wgray;
      for (int i = 1; i < SYNC_STAGES; i++)
        wq[i] <= wq[i-1];
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Scoreboard bench for async_fifo_gray: directed corners
// plus randomized traffic at two clock ratios.
`timescale 1ns/10ps
module tb_async_fifo_gray;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int SS = 2;
  localparam int DEPTH = 8;
  localparam logic [AW:0] DEP = 4'd8;

  logic          wclk, rclk, nRst, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_full, wr_almost_full, wr_overflow;
  logic          rd_valid, rd_empty, rd_almost_empty;
  logic          rd_underflow;
  logic [AW:0]   wr_level, rd_level;

  realtime whalf = 5.0;
  realtime rhalf = 8.5;
  int tests = 0;
  int fails = 0;
  int npop = 0;
  int n;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_pop = '0;

  async_fifo_gray #(
    .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS)
  ) dut (
    .wclk(wclk), .rclk(rclk), .nRst(nRst),
    .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .wr_level(wr_level), .wr_overflow(wr_overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_empty(rd_empty), .rd_almost_empty(rd_almost_empty),
    .rd_level(rd_level), .rd_underflow(rd_underflow)
  );

  initial begin wclk = 0; forever #(whalf) wclk = ~wclk; end
  initial begin rclk = 0; forever #(rhalf) rclk = ~rclk; end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wtick(); @(posedge wclk); #0.1; endtask
  task automatic rtick(); @(posedge rclk); #0.1; endtask

  // Monitor: every presented word must be the oldest written one.
  initial forever begin
    rtick();
    if (rd_valid) begin
      npop++;
      last_pop = rd_data;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %0h expected none",
                 rd_data);
      end else begin
        chk("sb_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #50ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    nRst = 0;
    wr_en = 0;
    rd_en = 0;
    exp_q.delete();
    #23;
    nRst = 1;
    npop = 0;
    repeat (2) rtick();
    repeat (2) wtick();
  endtask

  task automatic chk_idle();
    chk("idle_rd_empty", 32'(rd_empty), 1);
    chk("idle_rd_ae", 32'(rd_almost_empty), 1);
    chk("idle_wr_full", 32'(wr_full), 0);
    chk("idle_wr_af", 32'(wr_almost_full), 0);
    chk("idle_wr_level", 32'(wr_level), 0);
    chk("idle_rd_level", 32'(rd_level), 0);
    chk("idle_rd_valid", 32'(rd_valid), 0);
    chk("idle_rd_data", 32'(rd_data), 0);
    chk("idle_overflow", 32'(wr_overflow), 0);
    chk("idle_underflow", 32'(rd_underflow), 0);
  endtask

  task automatic run_random(input realtime wh,
                            input realtime rh,
                            input int nw);
    whalf = wh;
    rhalf = rh;
    do_reset();
    fork
      begin
        int i;
        i = 0;
        for (int c = 0; c < 40 * nw && i < nw; c++) begin
          wtick();
          chk("wr_level_range", 32'(wr_level <= DEP), 1);
          chk("wr_full_level", 32'(wr_full),
              32'(wr_level == DEP));
          if (!wr_full && $urandom_range(7) != 0) begin
            wr_en = 1;
            wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
            i++;
          end else begin
            wr_en = 0;
          end
        end
        wtick();
        wr_en = 0;
      end
      begin
        for (int c = 0; c < 40 * nw && npop < nw; c++) begin
          rtick();
          chk("rd_level_range", 32'(rd_level <= DEP), 1);
          chk("rd_empty_level", 32'(rd_empty),
              32'(rd_level == 0));
          rd_en = !rd_empty && ($urandom_range(7) != 0);
        end
        rd_en = 0;
      end
    join
    repeat (4) rtick();
    chk("rand_pop_count", 32'(npop), 32'(nw));
    chk("rand_sb_left", 32'(exp_q.size()), 0);
    chk("rand_overflow", 32'(wr_overflow), 0);
    chk("rand_underflow", 32'(rd_underflow), 0);
  endtask

  initial begin
    nRst = 0;
    wr_en = 0;
    rd_en = 0;
    wr_data = '0;
    do_reset();
    chk_idle();

    // Fill to full, then one write too many.
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 1;
      wr_data = 8'(i);
      exp_q.push_back(wr_data);
      wtick();
      chk("fill_level", 32'(wr_level), 32'(i));
      chk("fill_full", 32'(wr_full), 32'(i == DEPTH));
      chk("fill_af", 32'(wr_almost_full), 32'(i >= DEPTH - 1));
    end
    wr_data = 8'hFF;
    wtick();
    wr_en = 0;
    chk("ovf_flag", 32'(wr_overflow), 1);
    chk("ovf_level", 32'(wr_level), 8);
    chk("ovf_full", 32'(wr_full), 1);

    npop = 0;
    for (int c = 0; c < 200 && npop < DEPTH; c++) begin
      rtick();
      rd_en = !rd_empty;
    end
    rd_en = 0;
    chk("drain_count", 32'(npop), 8);
    repeat (10) wtick();
    chk("drain_wr_full", 32'(wr_full), 0);
    chk("drain_wr_level", 32'(wr_level), 0);
    chk("drain_rd_empty", 32'(rd_empty), 1);
    chk("drain_last", 32'(last_pop), 8);
    chk("drain_underflow", 32'(rd_underflow), 0);

    // Single-word latency to rd_empty low.
    do_reset();
    wr_en = 1;
    wr_data = 8'hA5;
    exp_q.push_back(wr_data);
    @(posedge wclk);
    #0.1;
    wr_en = 0;
    for (n = 1; n <= 10; n++) begin
      rtick();
      if (!rd_empty) break;
    end
    chk("empty_latency", 32'(n), 32'(SS + 1));
    chk("lat_rd_level", 32'(rd_level), 1);
    chk("lat_rd_ae", 32'(rd_almost_empty), 1);
    rd_en = 1;
    rtick();
    rd_en = 0;
    chk("pop_valid", 32'(rd_valid), 1);
    chk("pop_data", 32'(rd_data), 32'h A5);
    chk("pop_empty", 32'(rd_empty), 1);

    // Read while empty.
    rd_en = 1;
    repeat (4) rtick();
    chk("udf_flag", 32'(rd_underflow), 1);
    chk("udf_data_held", 32'(rd_data), 32'h A5);
    chk("udf_valid", 32'(rd_valid), 0);
    rd_en = 0;
    repeat (3) rtick();
    chk("udf_sticky", 32'(rd_underflow), 1);
    do_reset();
    chk_idle();

    run_random(5.0, 15.0, 5000);
    run_random(17.5, 5.0, 5000);

    // Reset in the middle of a burst with the FIFO half full.
    whalf = 5.0;
    rhalf = 8.5;
    do_reset();
    for (int i = 0; i < DEPTH / 2; i++) begin
      wr_en = 1;
      wr_data = 8'($urandom);
      exp_q.push_back(wr_data);
      wtick();
    end
    chk("half_level", 32'(wr_level), 4);
    wr_data = 8'h77;
    #2;
    nRst = 0;
    wr_en = 0;
    exp_q.delete();
    #1;
    chk_idle();
    #20;
    nRst = 1;
    repeat (2) rtick();
    repeat (2) wtick();
    npop = 0;
    wr_en = 1;
    wr_data = 8'h3C;
    exp_q.push_back(wr_data);
    wtick();
    wr_en = 0;
    for (int c = 0; c < 100 && npop < 1; c++) begin
      rtick();
      rd_en = !rd_empty && npop == 0;
    end
    rd_en = 0;
    repeat (3) rtick();
    chk("rst_first_count", 32'(npop), 1);
    chk("rst_first_word", 32'(last_pop), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
